// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the fifo write-side control logic: FSM encodings
// and helpers that derive depth and pointer widths from the parameters.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_STALL = 2'b10
  } state_e;

  // Number of words the fifo holds for a given address width.
  function automatic int depth_of(input int addr_size);
    return 32'sd1 << addr_size;
  endfunction

  // Width of a pointer that selects one of num_req producers (at least 1 bit).
  function automatic int ptr_width(input int num_req);
    return (num_req > 32'sd1) ? $clog2(num_req) : 32'sd1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first set bit of the eligible vector
// starting at rr_ptr and wrapping modulo NUM_REQ.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               found,
  output logic [NUM_REQ-1:0] select,
  output logic [PTR_W-1:0]   index
);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] pos_s;
  logic             hit_s;

  // Walk the candidates in priority order; the first eligible one wins.
  always_comb begin
    found  = 1'b0;
    select = '0;
    index  = '0;
    sum_s  = '0;
    pos_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s  = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      sum_s  = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? (sum_s - (PTR_W+1)'(NUM_REQ)) : sum_s;
      pos_s  = sum_s[PTR_W-1:0];
      hit_s  = !found && eligible[pos_s];
      select[pos_s] = select[pos_s] | hit_s;
      index  = hit_s ? pos_s : index;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side scheduler for the shared fifo. Producers share the
// single push port; a shadow occupancy count (credit) guarantees the fifo is
// never pushed while full. Consumer pops come back as pop_done credit returns.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_SIZE    = 8,
  parameter int ADDRESS_SIZE = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           fifo_push,
  output logic                           fifo_can_write,
  output logic [DATA_SIZE-1:0]           fifo_data_in,
  input  logic                           pop_done,
  output logic [ADDRESS_SIZE:0]          occupancy,
  output logic                           stall,
  output logic                           err_underflow
);

  localparam int DEPTH = depth_of(ADDRESS_SIZE);
  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int OCC_W = ADDRESS_SIZE + 1;
  localparam logic [OCC_W:0] DEPTH_V = (OCC_W+1)'(DEPTH);

  state_e               state_r;
  state_e               state_next_s;
  logic [PTR_W-1:0]     rr_ptr_r;
  logic [PTR_W-1:0]     ptr_next_s;
  logic [OCC_W-1:0]     occ_r;
  logic [OCC_W-1:0]     occ_next_s;
  logic [OCC_W:0]       occ_sum_s;
  logic [NUM_REQ-1:0]   gnt_r;
  logic                 push_r;
  logic [DATA_SIZE-1:0] data_r;
  logic                 stall_r;
  logic                 err_r;

  logic [NUM_REQ-1:0]   eligible_s;
  logic                 found_s;
  logic [NUM_REQ-1:0]   select_s;
  logic [PTR_W-1:0]     index_s;
  logic                 credit_s;
  logic                 grant_s;
  logic                 pop_take_s;
  logic [DATA_SIZE-1:0] data_sel_s;

  // A producer granted this cycle is still holding req; mask it so a lone
  // producer cannot be granted the same word twice.
  assign eligible_s = req & ~gnt_r;

  // Credit counts the push now on the bus but not a pop seen this cycle;
  // a returned credit becomes usable one cycle later, which cannot overfill.
  assign occ_sum_s  = {1'b0, occ_r} + {{OCC_W{1'b0}}, push_r};
  assign credit_s   = (occ_sum_s < DEPTH_V);
  assign pop_take_s = pop_done && (occ_r != '0);
  assign data_sel_s = req_data[int'(index_s)*DATA_SIZE +: DATA_SIZE];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .eligible (eligible_s),
    .rr_ptr   (rr_ptr_r),
    .found    (found_s),
    .select   (select_s),
    .index    (index_s)
  );

  // Next-state logic: every state re-evaluates demand and credit at each edge.
  always_comb begin
    state_next_s = ST_IDLE;
    grant_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_GRANT, ST_STALL: begin
        if (found_s) begin
          if (credit_s) begin
            state_next_s = ST_GRANT;
            grant_s      = 1'b1;
          end else begin
            state_next_s = ST_STALL;
            grant_s      = 1'b0;
          end
        end else begin
          state_next_s = ST_IDLE;
          grant_s      = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        grant_s      = 1'b0;
      end
    endcase
  end

  // Round-robin pointer advances past the winner; it holds when nobody wins.
  always_comb begin
    ptr_next_s = rr_ptr_r;
    if (grant_s) begin
      ptr_next_s = (index_s == PTR_W'(NUM_REQ-1)) ? '0 : (index_s + PTR_W'(1'b1));
    end else begin
      ptr_next_s = rr_ptr_r;
    end
  end

  // Shadow occupancy: +1 per push, -1 per pop, saturating at zero on underflow.
  always_comb begin
    occ_next_s = occ_r;
    if (push_r && !pop_take_s) begin
      occ_next_s = occ_r + OCC_W'(1'b1);
    end else if (!push_r && pop_take_s) begin
      occ_next_s = occ_r - OCC_W'(1'b1);
    end else begin
      occ_next_s = occ_r;
    end
  end

  // FSM state, pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      state_r  <= state_next_s;
      rr_ptr_r <= ptr_next_s;
      occ_r    <= occ_next_s;
    end
  end

  // Grant, push strobe and stall are registered together so they line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r   <= '0;
      push_r  <= 1'b0;
      stall_r <= 1'b0;
    end else begin
      gnt_r   <= grant_s ? select_s : '0;
      push_r  <= grant_s;
      stall_r <= (state_next_s == ST_STALL);
    end
  end

  // Push data captures the winner's word; it holds between pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
    end else if (grant_s) begin
      data_r <= data_sel_s;
    end else begin
      data_r <= data_r;
    end
  end

  // Underflow flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (pop_done && (occ_r == '0)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign gnt            = gnt_r;
  assign fifo_push      = push_r;
  assign fifo_can_write = push_r;
  assign fifo_data_in   = data_r;
  assign occupancy      = occ_r;
  assign stall          = stall_r;
  assign err_underflow  = err_r;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a behavioural model predicts each
// push (producer and word) into a queue; a negedge monitor pops and compares.
module tb_fifo_write_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic             pop_done;
  logic [NR-1:0]    gnt;
  logic             fifo_push;
  logic             fifo_can_write;
  logic [DW-1:0]    fifo_data_in;
  logic [AW:0]      occupancy;
  logic             stall;
  logic             err_underflow;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_push      (fifo_push),
    .fifo_can_write (fifo_can_write),
    .fifo_data_in   (fifo_data_in),
    .pop_done       (pop_done),
    .occupancy      (occupancy),
    .stall          (stall),
    .err_underflow  (err_underflow)
  );

  typedef struct packed {
    logic [4:0] occ;
    logic [1:0] ptr;
    logic [3:0] gmask;
    logic       push;
    logic       stall;
    logic       err;
    logic       hit;
    logic [1:0] idx;
    logic [7:0] data;
  } mst_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  mst_t ms;
  mst_t ms_nxt;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one edge of the scheduler in plain arithmetic.
  function automatic mst_t model_next(mst_t s, logic [3:0] rq, logic [31:0] rd, logic pop);
    mst_t       n;
    int         occ_i;
    int         pick;
    bit         found;
    logic [3:0] elig;
    n     = s;
    elig  = rq & ~s.gmask;
    occ_i = int'(s.occ);
    found = 1'b0;
    pick  = 0;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (int'(s.ptr) + k) % NR;
      if (!found && elig[i]) begin
        found = 1'b1;
        pick  = i;
      end
    end
    n.occ = 5'(occ_i + int'(s.push) - ((pop && occ_i > 0) ? 1 : 0));
    n.err = s.err | (pop && occ_i == 0);
    if (found && (occ_i + int'(s.push) < DEPTH)) begin
      n.hit   = 1'b1;
      n.idx   = 2'(pick);
      n.data  = rd[pick*8 +: 8];
      n.gmask = 4'(1 << pick);
      n.push  = 1'b1;
      n.stall = 1'b0;
      n.ptr   = 2'((pick + 1) % NR);
    end else begin
      n.hit   = 1'b0;
      n.gmask = 4'b0000;
      n.push  = 1'b0;
      n.stall = (elig != 4'b0000);
    end
    return n;
  endfunction

  always_comb ms_nxt = model_next(ms, req, req_data, pop_done);

  // Model state advances on each edge; predicted pushes go into the scoreboard.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms <= '0;
      exp_q.delete();
    end else begin
      ms <= ms_nxt;
      if (ms_nxt.hit) exp_q.push_back({ms_nxt.idx, ms_nxt.data});
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("push", 32'(fifo_push), 32'(ms.push));
      chk("can_write", 32'(fifo_can_write), 32'(ms.push));
      chk("occupancy", 32'(occupancy), 32'(ms.occ));
      chk("stall", 32'(stall), 32'(ms.stall));
      chk("err_underflow", 32'(err_underflow), 32'(ms.err));
      if (fifo_push) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL sb_push: got push of 0x%0h expected no push at %0t", fifo_data_in, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(4'b0001 << mon_e.idx));
          chk("sb_data", 32'(fifo_data_in), 32'(mon_e.data));
        end
      end else begin
        chk("gnt_idle", 32'(gnt), 32'd0);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          compared++;
          mismatched++;
          $display("FAIL sb_missing: got no push expected push of 0x%0h at %0t", mon_e.data, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    pop_done = 1'b0;
    for (int i = 0; i < NR; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] expg;
    logic [7:0] expd;
    int         n;

    // Async reset mid-burst, then the first full round-robin fill.
    do_reset();
    req = 4'hF;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_push", 32'(fifo_push), 32'd0);
    chk("rst_can_write", 32'(fifo_can_write), 32'd0);
    chk("rst_data", 32'(fifo_data_in), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      expg = 4'b0001 << (k % 4);
      chk("fill_order", 32'(gnt), 32'(expg));
    end
    tick();
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_push", 32'(fifo_push), 32'd0);
    tick();
    chk("full_hold_push", 32'(fifo_push), 32'd0);

    // One credit return lets exactly one more word in, to producer 0.
    pop_done = 1'b1;
    tick();
    pop_done = 1'b0;
    chk("pop_occ", 32'(occupancy), 32'd7);
    chk("pop_gnt", 32'(gnt), 32'd0);
    chk("pop_stall", 32'(stall), 32'd1);
    tick();
    chk("credit_gnt", 32'(gnt), 32'h1);
    chk("credit_push", 32'(fifo_push), 32'd1);
    tick();
    chk("refull_stall", 32'(stall), 32'd1);
    chk("refull_occ", 32'(occupancy), 32'd8);
    chk("refull_gnt", 32'(gnt), 32'd0);

    // Lone producer 2 with incrementing data: grants every other cycle.
    do_reset();
    req_data[23:16] = 8'h10;
    req = 4'b0100;
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk("lone_push", 32'(fifo_push), 32'(t % 2));
      if (t % 2 == 1) begin
        expd = 8'h10 + 8'((t - 1) / 2);
        chk("lone_data", 32'(fifo_data_in), 32'(expd));
        chk("lone_gnt", 32'(gnt), 32'h4);
      end
      if (gnt[2]) req_data[23:16] = req_data[23:16] + 8'h01;
    end

    // Push and pop in the same cycle at occupancy 5.
    do_reset();
    req = 4'hF;
    n = 0;
    while (!(occupancy == 4'd5 && fifo_push) && n < 20) begin
      tick();
      n++;
    end
    chk("pp_setup_occ", 32'(occupancy), 32'd5);
    pop_done = 1'b1;
    tick();
    pop_done = 1'b0;
    req = 4'h0;
    chk("pp_occ", 32'(occupancy), 32'd5);
    chk("pp_err", 32'(err_underflow), 32'd0);

    // Underflow sets a sticky flag; random traffic follows without reset.
    do_reset();
    pop_done = 1'b1;
    tick();
    pop_done = 1'b0;
    chk("uf_err", 32'(err_underflow), 32'd1);
    chk("uf_occ", 32'(occupancy), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[i*8 +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
      pop_done = (ms.occ != 5'd0) && ($urandom_range(0, 3) < ((c < 1500) ? 1 : 3));
      tick();
    end

    req      = '0;
    pop_done = 1'b0;
    tick(); tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
